// File: rtl/delta_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : delta_spike_encoder
// Purpose  : Delta-modulation encoder that turns 8-bit samples into up/down
//            spike bursts, with a refractory hold after each non-empty burst.
//            Optional per-direction spike counters: DELTA_SPIKE_CNT_EN.
// Revision : 1.0
// ============================================================================
module delta_spike_encoder #(
    parameter int MAX_BURST      = 16,
    parameter int REFRACT_CYCLES = 2,
    parameter int INIT_REF       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [7:0] threshold,
    output logic       spike_up,
    output logic       spike_down,
    output logic       busy,
    output logic [7:0] ref_out
`ifdef DELTA_SPIKE_CNT_EN
    ,
    input  logic       cnt_clr,
    output logic [7:0] cnt_up,
    output logic [7:0] cnt_down
`endif
);

    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);
    localparam logic [7:0] c_REFRACT   = 8'(REFRACT_CYCLES);
    localparam logic [7:0] c_INIT_REF  = 8'(INIT_REF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_ref;
    logic [7:0] r_target;
    logic [7:0] r_thr;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_refract_cnt;
    logic       r_spike_up;
    logic       r_spike_down;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [7:0] w_ref_nxt;
    logic [7:0] w_target_nxt;
    logic [7:0] w_thr_nxt;
    logic [7:0] w_burst_nxt;
    logic [7:0] w_refract_nxt;
    logic       w_up;
    logic       w_dn;
    logic       w_ready;
    logic [8:0] w_diff_up;
    logic [8:0] w_diff_dn;
    logic [8:0] w_thr9;

    assign w_ready      = rst_n && ena && (r_state == ST_IDLE);
    assign sample_ready = w_ready;
    assign spike_up     = r_spike_up;
    assign spike_down   = r_spike_down;
    assign busy         = r_busy;
    assign ref_out      = r_ref;

    // 9-bit signed residuals in both directions avoid any wrap ambiguity
    assign w_diff_up = {1'b0, r_target} - {1'b0, r_ref};
    assign w_diff_dn = {1'b0, r_ref} - {1'b0, r_target};
    assign w_thr9    = {1'b0, r_thr};

    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_target_nxt  = r_target;
        w_thr_nxt     = r_thr;
        w_burst_nxt   = r_burst_cnt;
        w_refract_nxt = r_refract_cnt;
        w_up          = 1'b0;
        w_dn          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample_valid && w_ready) begin
                    w_target_nxt = sample_in;
                    w_thr_nxt    = (threshold == 8'd0) ? 8'd1 : threshold;
                    w_state_nxt  = ST_BURST;
                end
            end
            ST_BURST: begin
                if (r_burst_cnt != c_MAX_BURST &&
                    $signed(w_diff_up) >= $signed(w_thr9)) begin
                    w_up        = 1'b1;
                    w_ref_nxt   = r_ref + r_thr;
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end else if (r_burst_cnt != c_MAX_BURST &&
                             $signed(w_diff_dn) >= $signed(w_thr9)) begin
                    w_dn        = 1'b1;
                    w_ref_nxt   = r_ref - r_thr;
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end else begin
                    w_burst_nxt = 8'd0;
                    if (r_burst_cnt != 8'd0 && c_REFRACT != 8'd0) begin
                        w_state_nxt   = ST_REFRACT;
                        w_refract_nxt = c_REFRACT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_REFRACT: begin
                if (r_refract_cnt <= 8'd1) begin
                    w_refract_nxt = 8'd0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_refract_nxt = r_refract_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ref         <= c_INIT_REF;
            r_target      <= 8'd0;
            r_thr         <= 8'd1;
            r_burst_cnt   <= 8'd0;
            r_refract_cnt <= 8'd0;
            r_spike_up    <= 1'b0;
            r_spike_down  <= 1'b0;
            r_busy        <= 1'b0;
        end else if (ena) begin
            r_state       <= w_state_nxt;
            r_ref         <= w_ref_nxt;
            r_target      <= w_target_nxt;
            r_thr         <= w_thr_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_refract_cnt <= w_refract_nxt;
            r_spike_up    <= w_up;
            r_spike_down  <= w_dn;
            r_busy        <= (w_state_nxt != ST_IDLE);
        end else begin
            // frozen: only the one-cycle spike pulses are allowed to drop
            r_spike_up    <= 1'b0;
            r_spike_down  <= 1'b0;
        end
    end

`ifdef DELTA_SPIKE_CNT_EN
    logic [7:0] r_cnt_up;
    logic [7:0] r_cnt_down;

    assign cnt_up   = r_cnt_up;
    assign cnt_down = r_cnt_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_up   <= 8'd0;
            r_cnt_down <= 8'd0;
        end else if (ena) begin
            if (cnt_clr) begin
                r_cnt_up   <= 8'd0;
                r_cnt_down <= 8'd0;
            end else begin
                if (w_up) r_cnt_up <= r_cnt_up + 8'd1;
                if (w_dn) r_cnt_down <= r_cnt_down + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_delta_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_delta_spike_encoder
// Purpose  : Directed self-checking bench for delta_spike_encoder.
// Revision : 1.0
// ============================================================================
module tb_delta_spike_encoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] threshold;
    logic       spike_up;
    logic       spike_down;
    logic       busy;
    logic [7:0] ref_out;
`ifdef DELTA_SPIKE_CNT_EN
    logic       cnt_clr;
    logic [7:0] cnt_up;
    logic [7:0] cnt_down;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    delta_spike_encoder #(
        .MAX_BURST     (16),
        .REFRACT_CYCLES(2),
        .INIT_REF      (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .threshold   (threshold),
        .spike_up    (spike_up),
        .spike_down  (spike_down),
        .busy        (busy),
        .ref_out     (ref_out)
`ifdef DELTA_SPIKE_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .cnt_up      (cnt_up),
        .cnt_down    (cnt_down)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!sample_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(sample_ready), 1);
    endtask

    initial begin
        int  n;
        logic both;
        rst_n        = 1'b0;
        ena          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'd0;
        threshold    = 8'd10;
`ifdef DELTA_SPIKE_CNT_EN
        cnt_clr      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_spike_up",   32'(spike_up), 0);
        chk("rst_spike_down", 32'(spike_down), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_ref",        32'(ref_out), 0);
        chk("rst_ready",      32'(sample_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(sample_ready), 1);

        // sample 35, threshold 10: three up spikes, then refractory
        send(8'd35);
        chk("t1_busy_e0",  32'(busy), 1);
        chk("t1_ready_e0", 32'(sample_ready), 0);
        chk("t1_up_e0",    32'(spike_up), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t1_up", 32'(spike_up), 1);
            chk("t1_ref", 32'(ref_out), 32'(10 * k));
        end
        @(negedge clk);
        chk("t1_up_e4",    32'(spike_up), 0);
        chk("t1_ref_e4",   32'(ref_out), 30);
        chk("t1_busy_e4",  32'(busy), 1);
        chk("t1_ready_e4", 32'(sample_ready), 0);
        @(negedge clk);
        chk("t1_ready_e5", 32'(sample_ready), 0);
        @(negedge clk);
        chk("t1_ready_e6", 32'(sample_ready), 1);
        chk("t1_busy_e6",  32'(busy), 0);

        // from ref 30, sample 5: two down spikes
        send(8'd5);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("t2_down", 32'(spike_down), 1);
            chk("t2_up",   32'(spike_up), 0);
            chk("t2_ref",  32'(ref_out), 32'(30 - 10 * k));
        end
        @(negedge clk);
        chk("t2_down_e3",  32'(spike_down), 0);
        chk("t2_ready_e3", 32'(sample_ready), 0);
        repeat (2) @(negedge clk);
        chk("t2_ready_e5", 32'(sample_ready), 1);
        // residual below threshold: no spikes, no refractory
        send(8'd14);
        chk("t2b_ready_e0", 32'(sample_ready), 0);
        @(negedge clk);
        chk("t2b_ready_e1", 32'(sample_ready), 1);
        chk("t2b_busy_e1",  32'(busy), 0);
        chk("t2b_spikes",   32'({spike_up, spike_down}), 0);
        chk("t2b_ref",      32'(ref_out), 10);

        // threshold 0 acts as 1; bursts capped at 16 spikes
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        threshold = 8'd0;
        @(negedge clk);
        chk("t3_ref_rst", 32'(ref_out), 0);
        both = 1'b0;
        for (int b = 1; b <= 2; b++) begin
            send(8'd255);
            n = 0;
            repeat (25) begin
                @(negedge clk);
                if (spike_up) n++;
                if (spike_up && spike_down) both = 1'b1;
            end
            chk("t3_count", 32'(n), 16);
            chk("t3_ref",   32'(ref_out), 32'(16 * b));
            chk("t3_ready", 32'(sample_ready), 1);
        end
        chk("t3_both_high", 32'(both), 0);

        // ena low for 5 cycles after the 2nd spike of a 3-spike burst
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        threshold = 8'd10;
        @(negedge clk);
        send(8'd35);
        repeat (2) @(negedge clk);
        chk("t4_up_e2",  32'(spike_up), 1);
        chk("t4_ref_e2", 32'(ref_out), 20);
        ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_frozen",       32'({spike_up, spike_down, ref_out}), 32'({2'b00, 8'd20}));
            chk("t4_ready_frozen", 32'(sample_ready), 0);
        end
        ena = 1'b1;
        @(negedge clk);
        chk("t4_up_resume",  32'(spike_up), 1);
        chk("t4_ref_resume", 32'(ref_out), 30);
        @(negedge clk);
        chk("t4_up_end",  32'(spike_up), 0);
        chk("t4_ref_end", 32'(ref_out), 30);
        wait_idle("t4_idle");

        // asynchronous reset mid-burst
        send(8'd100);
        @(negedge clk);
        chk("t5_up_e1",  32'(spike_up), 1);
        chk("t5_ref_e1", 32'(ref_out), 40);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_up",    32'(spike_up), 0);
        chk("t5_rst_ref",   32'(ref_out), 0);
        chk("t5_rst_busy",  32'(busy), 0);
        chk("t5_rst_ready", 32'(sample_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd20);
        @(negedge clk);
        chk("t5_up_a",  32'(spike_up), 1);
        chk("t5_ref_a", 32'(ref_out), 10);
        @(negedge clk);
        chk("t5_up_b",  32'(spike_up), 1);
        chk("t5_ref_b", 32'(ref_out), 20);
        @(negedge clk);
        chk("t5_up_c",  32'(spike_up), 0);
        wait_idle("t5_idle");

`ifdef DELTA_SPIKE_CNT_EN
        // 260 up spikes and 256 down spikes with threshold 1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        threshold = 8'd1;
        @(negedge clk);
        for (int p = 0; p < 16; p++) begin
            send(8'd16);
            wait_idle("t6_idle_up");
            send(8'd0);
            wait_idle("t6_idle_dn");
        end
        send(8'd4);
        wait_idle("t6_idle_last");
        chk("t6_cnt_up_wrap",   32'(cnt_up), 4);
        chk("t6_cnt_down_wrap", 32'(cnt_down), 0);
        send(8'd14);
        @(negedge clk);
        chk("t6_cnt_up_pre", 32'(cnt_up), 5);
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_spike", 32'(spike_up), 1);
        chk("t6_clr_cnt",   32'(cnt_up), 0);
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("t6_cnt_after", 32'(cnt_up), 1);
        wait_idle("t6_idle_end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
